// File: rtl/counter_driver_if.sv
// Command and response channels of counter_driver.
// The master side issues commands and consumes responses; the slave side is the driver.
interface counter_driver_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [3:0]       cmd_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_count;
    logic [1:0]       rsp_flags;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_count, rsp_flags
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_count, rsp_flags
    );
endinterface

// File: rtl/counter_driver.sv
// Queues counter commands, drives an external up/down counter for the requested
// number of cycles, then reports the settled count and flags.
module counter_driver #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    counter_driver_if.slave  bus,
    output logic             load_n,
    output logic             up_down,
    output logic             ce,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, SETTLE, REPORT} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] data;
        logic [3:0]       len;
    } cmd_t;

    cmd_t             mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      occ;
    logic             full, empty, push, pop;
    cmd_t             head, act;
    state_t           state, next;
    logic [3:0]       len_cnt;
    logic [WIDTH-1:0] rsp_count_q;
    logic [1:0]       rsp_flags_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full          = (occ == (PW+1)'(FIFO_DEPTH));
    assign empty         = (occ == '0);
    assign bus.cmd_ready = !full && !rst;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head          = mem[rd_ptr];

    assign bus.rsp_valid = (state == REPORT);
    assign bus.rsp_count = rsp_count_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign busy          = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: bus.cmd_op, data: bus.cmd_data, len: bus.cmd_len};
    end

    always_comb begin
        next = state;
        pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop  = 1'b1;
                    next = APPLY;
                end
            end
            APPLY:  if (len_cnt <= 4'd1) next = SETTLE;
            SETTLE: next = REPORT;
            REPORT: begin
                if (bus.rsp_ready) begin
                    if (!empty) begin
                        pop  = 1'b1;
                        next = APPLY;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    // Counter controls are pure Moore outputs of the active command in APPLY.
    always_comb begin
        ce        = 1'b0;
        load_n    = 1'b1;
        up_down   = 1'b0;
        data_load = '0;
        if (state == APPLY) begin
            case (act.op)
                2'b01: begin ce = 1'b1; up_down = 1'b1; end
                2'b10: ce = 1'b1;
                2'b11: begin ce = 1'b1; load_n = 1'b0; data_load = act.data; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            act         <= '0;
            len_cnt     <= '0;
            rsp_count_q <= '0;
            rsp_flags_q <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
        end else begin
            state <= next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
            if (pop) begin
                act     <= head;
                len_cnt <= (head.len == 4'd0) ? 4'd1 : head.len;
            end else if (state == APPLY) begin
                len_cnt <= len_cnt - 1'b1;
            end
            // Counter outputs have had one full cycle to settle by the end of SETTLE.
            if (state == SETTLE) begin
                rsp_count_q <= count_out;
                rsp_flags_q <= {max_count, zero};
            end
        end
    end
endmodule

// File: tb/tb_counter_driver.sv
// Directed bench for counter_driver with a behavioural up/down counter attached.
module tb_counter_driver;
    localparam int WIDTH = 4;
    localparam logic [1:0] HOLD = 2'b00, UP = 2'b01, DOWN = 2'b10, LOAD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_n, up_down, ce, max_count, zero, busy;
    logic [WIDTH-1:0] data_load, count_out, cnt;

    always #5 clk = ~clk;

    counter_driver_if #(.WIDTH(WIDTH)) bus ();

    counter_driver #(.WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .load_n(load_n), .up_down(up_down), .ce(ce), .data_load(data_load),
        .count_out(count_out), .max_count(max_count), .zero(zero), .busy(busy)
    );

    // The external counter being driven.
    always @(posedge clk) begin
        if (rst)          cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce)      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign count_out = cnt;
    assign max_count = &cnt;
    assign zero      = (cnt == '0);

    typedef struct {logic [1:0] op; logic [3:0] data; logic [3:0] len;} cmd_s;
    typedef struct {logic [3:0] count; logic [1:0] flags; int cyc;} rsp_s;

    cmd_s q[$];
    rsp_s rq[$];
    int   accepts = 0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total = 0;
    logic lce [0:4095];
    logic lld [0:4095];
    logic lud [0:4095];

    // Command driver: presents the head of q until it is accepted.
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        forever begin
            @(posedge clk);
            if (bus.cmd_valid && bus.cmd_ready && q.size() > 0) begin
                q.delete(0);
                accepts++;
            end
            #1;
            if (q.size() > 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = q[0].op;
                bus.cmd_data  = q[0].data;
                bus.cmd_len   = q[0].len;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
    end

    // Per-cycle log of counter controls and completed response handshakes.
    always @(posedge clk) begin
        if (cyc < 4096) begin
            lce[cyc] = ce;
            lld[cyc] = load_n;
            lud[cyc] = up_down;
        end
        if (bus.rsp_valid && bus.rsp_ready && !rst)
            rq.push_back('{bus.rsp_count, bus.rsp_flags, cyc});
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!busy && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic rsp_s rsp_at(input int i);
        rsp_s r;
        r.count = 'x;
        r.flags = 'x;
        r.cyc   = -100;
        if (i >= 0 && i < rq.size()) r = rq[i];
        return r;
    endfunction

    task automatic test_reset();
        int a0;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        tick(3);
        total++;
        if (bus.cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready);
        else pass_cnt++;
        total++;
        if ({load_n, ce, up_down, data_load, bus.rsp_valid, bus.rsp_count, bus.rsp_flags, busy}
            !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b0})
            $display("FAIL reset_outputs: got %b want 100000000000000",
                     {load_n, ce, up_down, data_load, bus.rsp_valid, bus.rsp_count, bus.rsp_flags, busy});
        else pass_cnt++;
        a0 = accepts;
        q.push_back('{UP, 4'd0, 4'd3});
        tick(2);
        total++;
        if ({bus.cmd_valid, bus.cmd_ready} !== 2'b10)
            $display("FAIL reset_offer_refused: got valid/ready %b want 10", {bus.cmd_valid, bus.cmd_ready});
        else pass_cnt++;
        q.delete();
        tick();
        rst = 1'b0;
        tick(2);
        total++;
        if ({busy, 4'(accepts - a0)} !== 5'b0)
            $display("FAIL reset_discard: got busy %b accepts %0d want 0 0", busy, accepts - a0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int  n0;
        bit  found;
        bus.rsp_ready = 1'b1;
        n0 = rq.size();
        q.push_back('{UP, 4'd0, 4'd8});
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ce && up_down) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) $display("FAIL midrst_apply_seen: got none want UP apply");
        else pass_cnt++;
        tick(2);
        rst = 1'b1;
        tick();
        total++;
        if ({ce, load_n, bus.rsp_valid, busy} !== 4'b0100)
            $display("FAIL midrst_outputs: got ce/load_n/rsp_valid/busy %b want 0100",
                     {ce, load_n, bus.rsp_valid, busy});
        else pass_cnt++;
        tick();
        rst = 1'b0;
        tick(20);
        total++;
        if (rq.size() != n0) $display("FAIL midrst_no_response: got %0d responses want 0", rq.size() - n0);
        else pass_cnt++;
        total++;
        if ({busy, bus.rsp_valid} !== 2'b00)
            $display("FAIL midrst_idle: got busy/rsp_valid %b want 00", {busy, bus.rsp_valid});
        else pass_cnt++;
    endtask

    task automatic test_load_count();
        int n0, c0, la, ua, ups;
        bit ok;
        rsp_s r;
        bus.rsp_ready = 1'b1;
        n0 = rq.size();
        c0 = cyc;
        q.push_back('{LOAD, 4'd9, 4'd1});
        q.push_back('{UP, 4'd0, 4'd3});
        wait_idle(ok);
        total++;
        if (!ok) $display("FAIL lc_idle: timed out");
        else pass_cnt++;
        r = rsp_at(n0);
        total++;
        if ({r.count, r.flags} !== {4'd9, 2'b00})
            $display("FAIL lc_rsp0: got %0d/%b want 9/00", r.count, r.flags);
        else pass_cnt++;
        r = rsp_at(n0 + 1);
        total++;
        if ({r.count, r.flags} !== {4'd12, 2'b00})
            $display("FAIL lc_rsp1: got %0d/%b want 12/00", r.count, r.flags);
        else pass_cnt++;
        la = -1; ua = -1; ups = 0;
        for (int c = c0; c < cyc && c < 4096; c++) begin
            if (lce[c] === 1'b1 && lld[c] === 1'b0) la = c;
            if (lce[c] === 1'b1 && lud[c] === 1'b1) begin
                ups++;
                if (ua < 0) ua = c;
            end
        end
        total++;
        if (ua - la != 3) $display("FAIL lc_gap: got %0d idle cycles want 2", ua - la - 1);
        else pass_cnt++;
        total++;
        if (ups != 3) $display("FAIL lc_up_cycles: got %0d want 3", ups);
        else pass_cnt++;
    endtask

    task automatic test_wrap_flags();
        int n0;
        bit ok;
        rsp_s r;
        bus.rsp_ready = 1'b1;
        n0 = rq.size();
        q.push_back('{LOAD, 4'd14, 4'd1});
        q.push_back('{UP,   4'd0,  4'd3});
        q.push_back('{LOAD, 4'd15, 4'd1});
        q.push_back('{LOAD, 4'd1,  4'd1});
        q.push_back('{DOWN, 4'd0,  4'd2});
        q.push_back('{LOAD, 4'd0,  4'd1});
        wait_idle(ok);
        total++;
        if (!ok) $display("FAIL wrap_idle: timed out");
        else pass_cnt++;
        r = rsp_at(n0 + 1);
        total++;
        if ({r.count, r.flags} !== {4'd1, 2'b00})
            $display("FAIL wrap_up: got %0d/%b want 1/00", r.count, r.flags);
        else pass_cnt++;
        r = rsp_at(n0 + 2);
        total++;
        if ({r.count, r.flags} !== {4'd15, 2'b10})
            $display("FAIL wrap_max_flag: got %0d/%b want 15/10", r.count, r.flags);
        else pass_cnt++;
        r = rsp_at(n0 + 4);
        total++;
        if ({r.count, r.flags} !== {4'd15, 2'b10})
            $display("FAIL wrap_down: got %0d/%b want 15/10", r.count, r.flags);
        else pass_cnt++;
        r = rsp_at(n0 + 5);
        total++;
        if ({r.count, r.flags} !== {4'd0, 2'b01})
            $display("FAIL wrap_zero_flag: got %0d/%b want 0/01", r.count, r.flags);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        int n0, ces;
        bit ok;
        rsp_s r0, r1;
        bus.rsp_ready = 1'b1;
        n0 = rq.size();
        q.push_back('{LOAD, 4'd5, 4'd1});
        q.push_back('{HOLD, 4'd0, 4'd0});
        wait_idle(ok);
        total++;
        if (!ok) $display("FAIL zl_idle: timed out");
        else pass_cnt++;
        r0 = rsp_at(n0);
        r1 = rsp_at(n0 + 1);
        total++;
        if ({r1.count, r1.flags} !== {4'd5, 2'b00})
            $display("FAIL zl_count: got %0d/%b want 5/00", r1.count, r1.flags);
        else pass_cnt++;
        total++;
        if (r1.cyc - r0.cyc != 3)
            $display("FAIL zl_apply_len: got %0d report spacing want 3", r1.cyc - r0.cyc);
        else pass_cnt++;
        ces = 0;
        for (int c = r0.cyc + 1; c <= r1.cyc && c >= 0 && c < 4096; c++)
            if (lce[c] !== 1'b0) ces++;
        total++;
        if (ces != 0) $display("FAIL zl_hold_ce: got %0d ce cycles want 0", ces);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int a0;
        bus.rsp_ready = 1'b0;
        a0 = accepts;
        q.push_back('{LOAD, 4'd3, 4'd1});
        for (int i = 0; i < 7; i++) q.push_back('{UP, 4'd0, 4'd1});
        tick(20);
        total++;
        if (accepts - a0 != 5) $display("FAIL bp_accepts: got %0d want 5", accepts - a0);
        else pass_cnt++;
        total++;
        if ({bus.cmd_valid, bus.cmd_ready} !== 2'b10)
            $display("FAIL bp_full: got valid/ready %b want 10", {bus.cmd_valid, bus.cmd_ready});
        else pass_cnt++;
        total++;
        if ({bus.rsp_valid, bus.rsp_count, bus.rsp_flags} !== {1'b1, 4'd3, 2'b00})
            $display("FAIL bp_report: got %b want 1001100", {bus.rsp_valid, bus.rsp_count, bus.rsp_flags});
        else pass_cnt++;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        tick(5);
        total++;
        if (accepts - a0 != 6) $display("FAIL bp_one_more: got %0d want 6", accepts - a0);
        else pass_cnt++;
    endtask

    task automatic test_stability();
        bit found, ok;
        int errs;
        rsp_s r;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!found) $display("FAIL stab_report: got no rsp_valid want 1");
        else pass_cnt++;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if ({bus.rsp_valid, bus.rsp_count, bus.rsp_flags, ce} !== {1'b1, 4'd4, 2'b00, 1'b0}) errs++;
            tick();
        end
        total++;
        if (errs != 0) $display("FAIL stab_hold: got %0d unstable cycles want 0", errs);
        else pass_cnt++;
        bus.rsp_ready = 1'b1;
        wait_idle(ok);
        total++;
        if (!ok) $display("FAIL stab_drain: timed out");
        else pass_cnt++;
        r = rsp_at(rq.size() - 1);
        total++;
        if (r.count !== 4'd10) $display("FAIL stab_final: got %0d want 10", r.count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_load_count();
        test_wrap_flags();
        test_zero_len();
        test_backpressure();
        test_stability();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
